ariane_regfile_wb_arbiter: RTL

Writer-side front end for the multi-port integer register file. It collects writeback requests from NR_WB_PORTS functional units over valid/ready handshakes and holds each one in a one-entry slot per source. Each cycle it grants up to NR_WRITE_PORTS pending writes round-robin. The granted writes drive the register file's we/waddr/wdata write ports through registered outputs. It also exports a pending-write bitmap to the issue stage for hazard checks.

---
 rtl/ariane_regfile_pkg.sv | 17 +
 rtl/ariane_rr_multi_grant.sv | 63 ++++++
 rtl/ariane_regfile_wb_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/ariane_regfile_pkg.sv
// Shared types and helpers for the integer register file write side.
package ariane_regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NR_REGS    = 32;
  localparam int unsigned XLEN       = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic [NR_REGS-1:0] onehot_reg(input logic [REG_ADDR_W-1:0] addr);
    return NR_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/ariane_rr_multi_grant.sv
// Combinational multi-grant round-robin picker; a slot whose address matches
// an earlier grant in scan order is held back this cycle.
module ariane_rr_multi_grant
  import ariane_regfile_pkg::*;
#(
  parameter int unsigned NR_SRC   = 4,
  parameter int unsigned NR_PORTS = 2,
  localparam int unsigned PTR_W   = (NR_SRC > 1) ? $clog2(NR_SRC) : 1
) (
  input  logic [NR_SRC-1:0]                  held,
  input  logic [NR_SRC-1:0][REG_ADDR_W-1:0]  addrs,
  input  logic [PTR_W-1:0]                   rr_ptr,
  output logic [NR_SRC-1:0]                  grant,
  output logic [NR_PORTS-1:0]                port_vld,
  output logic [NR_PORTS-1:0][PTR_W-1:0]     port_idx,
  output logic                               any_grant,
  output logic [PTR_W-1:0]                   last_idx
);

  always_comb begin
    logic [NR_SRC-1:0]              grant_v;
    logic [NR_PORTS-1:0]            vld_v;
    logic [NR_PORTS-1:0][PTR_W-1:0] idx_v;
    logic [PTR_W:0]                 sum;
    logic [PTR_W-1:0]               idx;
    logic                           conflict;
    int unsigned                    n_grant;
    grant_v   = '0;
    vld_v     = '0;
    idx_v     = '0;
    sum       = '0;
    idx       = '0;
    conflict  = 1'b0;
    n_grant   = 0;
    any_grant = 1'b0;
    last_idx  = '0;
    for (int unsigned k = 0; k < NR_SRC; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NR_SRC)) sum = sum - (PTR_W+1)'(NR_SRC);
      idx = PTR_W'(sum);
      conflict = 1'b0;
      for (int unsigned j = 0; j < NR_SRC; j++) begin
        if (grant_v[j] && (addrs[j] == addrs[idx])) conflict = 1'b1;
      end
      if (held[idx] && !conflict && (n_grant < NR_PORTS)) begin
        grant_v[idx] = 1'b1;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
          if (p == n_grant) begin
            vld_v[p] = 1'b1;
            idx_v[p] = idx;
          end
        end
        n_grant   = n_grant + 1;
        any_grant = 1'b1;
        last_idx  = idx;
      end
    end
    grant    = grant_v;
    port_vld = vld_v;
    port_idx = idx_v;
  end

endmodule

// File: rtl/ariane_regfile_wb_arbiter.sv
// Collects writeback requests into one-entry slots per source and drives the
// register file write ports from a round-robin multi-grant arbiter.
module ariane_regfile_wb_arbiter
  import ariane_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = XLEN,
  parameter int unsigned NR_WB_PORTS    = 4,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter bit          ZERO_REG_ZERO  = 1'b1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
  output logic [NR_WB_PORTS-1:0]                      wb_ready_o,
  input  logic [NR_WB_PORTS-1:0][REG_ADDR_W-1:0]      wb_addr_i,
  input  logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0]      wb_data_i,
  output logic [NR_WRITE_PORTS-1:0]                   we_o,
  output logic [NR_WRITE_PORTS-1:0][REG_ADDR_W-1:0]   waddr_o,
  output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]   wdata_o,
  output logic [NR_REGS-1:0]                          pending_o
);

  localparam int unsigned PTR_W = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

  wb_req_t [NR_WB_PORTS-1:0]              slot_q;
  logic    [NR_WB_PORTS-1:0]              held_q;
  logic    [PTR_W-1:0]                    rr_ptr_q;
  logic    [NR_WB_PORTS-1:0][REG_ADDR_W-1:0] slot_addr;
  logic    [NR_WB_PORTS-1:0]              grant;
  logic    [NR_WRITE_PORTS-1:0]           port_vld;
  logic    [NR_WRITE_PORTS-1:0][PTR_W-1:0] port_idx;
  logic                                   any_grant;
  logic    [PTR_W-1:0]                    last_idx;

  always_comb begin
    for (int unsigned i = 0; i < NR_WB_PORTS; i++) slot_addr[i] = slot_q[i].addr;
  end

  ariane_rr_multi_grant #(
    .NR_SRC   (NR_WB_PORTS),
    .NR_PORTS (NR_WRITE_PORTS)
  ) i_picker (
    .held      (held_q),
    .addrs     (slot_addr),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .port_vld  (port_vld),
    .port_idx  (port_idx),
    .any_grant (any_grant),
    .last_idx  (last_idx)
  );

  // A slot draining this cycle can take a new request in the same cycle.
  assign wb_ready_o = ~held_q | grant;

  always_comb begin
    pending_o = '0;
    for (int unsigned i = 0; i < NR_WB_PORTS; i++) begin
      if (held_q[i]) pending_o = pending_o | onehot_reg(slot_q[i].addr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q   <= '0;
      held_q   <= '0;
      rr_ptr_q <= '0;
      we_o     <= '0;
      waddr_o  <= '0;
      wdata_o  <= '0;
    end else begin
      for (int unsigned i = 0; i < NR_WB_PORTS; i++) begin
        if (wb_valid_i[i] && wb_ready_o[i]) begin
          // x0 writes are consumed without occupying the slot.
          held_q[i] <= !(ZERO_REG_ZERO && (wb_addr_i[i] == '0));
          slot_q[i] <= '{addr: wb_addr_i[i], data: XLEN'(wb_data_i[i])};
        end else if (grant[i]) begin
          held_q[i] <= 1'b0;
        end
      end
      we_o <= port_vld;
      for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
        if (port_vld[p]) begin
          waddr_o[p] <= slot_q[port_idx[p]].addr;
          wdata_o[p] <= DATA_WIDTH'(slot_q[port_idx[p]].data);
        end
      end
      if (any_grant) begin
        rr_ptr_q <= (last_idx == PTR_W'(NR_WB_PORTS - 1)) ? '0 : last_idx + PTR_W'(1);
      end
    end
  end

endmodule
